if_pc_stage: RTL and testbench

- Fetch-side PC generator and IF/ID PC pipeline register.
- Sits directly upstream of the IF/ID instruction register.
  - Drives the word address into the instruction cache.
  - Carries the fetch PC and branch-prediction bit into ID, in lockstep with the fetched instruction.
- Selects the next PC from EX redirects, ID jumps, an optional branch target buffer, or PC+4.

---
 rtl/if_pc_stage.sv | 147 ++++++++++++++
 tb/tb_if_pc_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_pc_stage.sv
// Fetch PC generator with the IF/ID PC/prediction register; redirects from EX and ID, PC+4 otherwise.
// Optional direct-mapped branch target buffer enabled by defining BTB_EN.
module if_pc_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BTB_IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubbleF,
   input  logic        bubbleD,
   input  logic        flushD,
   input  logic        jal_ID,
   input  logic [31:0] jal_target_ID,
   input  logic        jalr_EX,
   input  logic [31:0] jalr_target_EX,
   input  logic        br_EX,
   input  logic        br_taken_EX,
   input  logic [31:0] br_target_EX,
   input  logic [31:0] pc_EX,
   input  logic        pred_taken_EX,
   output logic [29:0] addr,
   output logic [31:0] pc_IF,
   output logic [31:0] pc_ID,
   output logic        pred_taken_ID,
   output logic        redirect_EX
);

   if ((BTB_IDX_W < 1) || (BTB_IDX_W > 28)) begin : g_bad_btb_idx_w
      $error("if_pc_stage: BTB_IDX_W must be within 1..28");
   end

   logic [31:0] r_pc_IF;
   logic [31:0] r_pc_ID;
   logic        r_pred_ID;
   logic [31:0] w_pc_next;
   logic        w_mispredict;
   logic        w_pred_IF;

`ifdef BTB_EN
   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = 30 - BTB_IDX_W;

   logic [BTB_N-1:0] r_btb_vld;
   logic [TAG_W-1:0] r_btb_tag [BTB_N];
   logic [31:0]      r_btb_tgt [BTB_N];
   logic [1:0]       r_btb_cnt [BTB_N];

   logic [BTB_IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0]     w_lk_tag;
   logic [31:0]          w_btb_tgt;
   logic [BTB_IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0]     w_up_tag;
   logic                 w_up_hit;

   assign w_lk_idx  = r_pc_IF[BTB_IDX_W+1:2];
   assign w_lk_tag  = r_pc_IF[31:BTB_IDX_W+2];
   assign w_pred_IF = r_btb_vld[w_lk_idx] & (r_btb_tag[w_lk_idx] == w_lk_tag)
                      & r_btb_cnt[w_lk_idx][1];
   assign w_btb_tgt = r_btb_tgt[w_lk_idx];

   assign w_up_idx = pc_EX[BTB_IDX_W+1:2];
   assign w_up_tag = pc_EX[31:BTB_IDX_W+2];
   assign w_up_hit = r_btb_vld[w_up_idx] & (r_btb_tag[w_up_idx] == w_up_tag);

   // Only valid bits are reset; tag/target/counter storage stays RAM-friendly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btb_vld <= '0;
      end else if (br_EX && !w_up_hit && br_taken_EX) begin
         r_btb_vld[w_up_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && br_EX) begin
         if (w_up_hit) begin
            r_btb_tgt[w_up_idx] <= br_target_EX;
            if (br_taken_EX) begin
               r_btb_cnt[w_up_idx] <= (r_btb_cnt[w_up_idx] == 2'b11) ? 2'b11
                                      : r_btb_cnt[w_up_idx] + 2'b01;
            end else begin
               r_btb_cnt[w_up_idx] <= (r_btb_cnt[w_up_idx] == 2'b00) ? 2'b00
                                      : r_btb_cnt[w_up_idx] - 2'b01;
            end
         end else if (br_taken_EX) begin
            r_btb_tag[w_up_idx] <= w_up_tag;
            r_btb_tgt[w_up_idx] <= br_target_EX;
            r_btb_cnt[w_up_idx] <= 2'b10;
         end
      end
   end
`else
   assign w_pred_IF = 1'b0;
`endif

   assign w_mispredict = br_EX & (br_taken_EX != pred_taken_EX);
   assign redirect_EX  = jalr_EX | w_mispredict;

   // EX redirects sit above bubbleF so a stalled front end never drops them.
   always_comb begin
      w_pc_next = r_pc_IF + 32'd4;
      if (jalr_EX) begin
         w_pc_next = {jalr_target_EX[31:1], 1'b0};
      end else if (w_mispredict) begin
         w_pc_next = br_taken_EX ? br_target_EX : pc_EX + 32'd4;
      end else if (bubbleF) begin
         w_pc_next = r_pc_IF;
      end else if (jal_ID) begin
         w_pc_next = jal_target_ID;
      end
`ifdef BTB_EN
      else if (w_pred_IF) begin
         w_pc_next = w_btb_tgt;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_IF <= RESET_PC;
      end else begin
         r_pc_IF <= w_pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc_ID   <= 32'd0;
         r_pred_ID <= 1'b0;
      end else if (bubbleD) begin
         r_pc_ID   <= r_pc_ID;
         r_pred_ID <= r_pred_ID;
      end else if (flushD) begin
         r_pc_ID   <= 32'd0;
         r_pred_ID <= 1'b0;
      end else begin
         r_pc_ID   <= r_pc_IF;
         r_pred_ID <= w_pred_IF;
      end
   end

   assign pc_IF         = r_pc_IF;
   assign addr          = r_pc_IF[31:2];
   assign pc_ID         = r_pc_ID;
   assign pred_taken_ID = r_pred_ID;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage; BTB scenarios are included when BTB_EN is defined.
module tb_if_pc_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        bubbleF, bubbleD, flushD;
   logic        jal_ID;
   logic [31:0] jal_target_ID;
   logic        jalr_EX;
   logic [31:0] jalr_target_EX;
   logic        br_EX, br_taken_EX;
   logic [31:0] br_target_EX;
   logic [31:0] pc_EX;
   logic        pred_taken_EX;
   logic [29:0] addr;
   logic [31:0] pc_IF;
   logic [31:0] pc_ID;
   logic        pred_taken_ID;
   logic        redirect_EX;

   int n_chk = 0;
   int n_err = 0;

   if_pc_stage #(.RESET_PC(32'h0000_0000), .BTB_IDX_W(4)) dut (
      .clk(clk), .rst(rst),
      .bubbleF(bubbleF), .bubbleD(bubbleD), .flushD(flushD),
      .jal_ID(jal_ID), .jal_target_ID(jal_target_ID),
      .jalr_EX(jalr_EX), .jalr_target_EX(jalr_target_EX),
      .br_EX(br_EX), .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
      .pc_EX(pc_EX), .pred_taken_EX(pred_taken_EX),
      .addr(addr), .pc_IF(pc_IF), .pc_ID(pc_ID),
      .pred_taken_ID(pred_taken_ID), .redirect_EX(redirect_EX)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; bubbleF = 1'b0; bubbleD = 1'b0; flushD = 1'b0;
      jal_ID = 1'b0; jal_target_ID = 32'd0;
      jalr_EX = 1'b0; jalr_target_EX = 32'd0;
      br_EX = 1'b0; br_taken_EX = 1'b0; br_target_EX = 32'd0;
      pc_EX = 32'd0; pred_taken_EX = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      chk("rst_pc_IF", pc_IF, 32'h0);
      chk("rst_pc_ID", pc_ID, 32'h0);
      chk("rst_pred", {31'd0, pred_taken_ID}, 32'd0);
      rst = 1'b0;

      // Free-running fetch: addr 0..3, pc_ID one behind.
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("seq_addr%0d", i), {2'b00, addr}, i);
         chk($sformatf("seq_pcID%0d", i), pc_ID, (i == 0) ? 32'd0 : 32'((i - 1) * 4));
         chk($sformatf("seq_redir%0d", i), {31'd0, redirect_EX}, 32'd0);
         step();
      end
      chk("seq_pcIF_10", pc_IF, 32'h10);
      chk("seq_pcID_0C", pc_ID, 32'h0C);

      // Two-cycle stall.
      bubbleF = 1'b1; bubbleD = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("stall_pcIF%0d", i), pc_IF, 32'h10);
         chk($sformatf("stall_pcID%0d", i), pc_ID, 32'h0C);
      end
      bubbleF = 1'b0; bubbleD = 1'b0;
      step();
      chk("rel_pcIF", pc_IF, 32'h14);
      chk("rel_pcID", pc_ID, 32'h10);

      // JALR beats bubbleF and mispredict; LSB cleared.
      jalr_EX = 1'b1; jalr_target_EX = 32'h0000_0101; bubbleF = 1'b1;
      br_EX = 1'b1; br_taken_EX = 1'b1; pred_taken_EX = 1'b0; br_target_EX = 32'h0000_0900;
      #1;
      chk("jalr_redir", {31'd0, redirect_EX}, 32'd1);
      step();
      idle();
      chk("jalr_pcIF", pc_IF, 32'h100);
      chk("jalr_addr", {2'b00, addr}, 32'h40);

      // Predicted-taken branch resolves not-taken: fall through to pc_EX+4, ID flushed.
      br_EX = 1'b1; br_taken_EX = 1'b0; pred_taken_EX = 1'b1; pc_EX = 32'h40;
      br_target_EX = 32'h0000_0700; bubbleF = 1'b1; flushD = 1'b1;
      #1;
      chk("mis_nt_redir", {31'd0, redirect_EX}, 32'd1);
      step();
      idle();
      chk("mis_nt_pcIF", pc_IF, 32'h44);
      chk("mis_nt_pcID", pc_ID, 32'h0);
      chk("mis_nt_pred", {31'd0, pred_taken_ID}, 32'd0);

      // Predicted-not-taken branch resolves taken.
      br_EX = 1'b1; br_taken_EX = 1'b1; pred_taken_EX = 1'b0; br_target_EX = 32'h200; pc_EX = 32'h44;
      step();
      idle();
      chk("mis_t_pcIF", pc_IF, 32'h200);

      // Correct prediction: no redirect, sequential fetch.
      br_EX = 1'b1; br_taken_EX = 1'b0; pred_taken_EX = 1'b0; br_target_EX = 32'h600; pc_EX = 32'h80;
      #1;
      chk("ok_br_redir", {31'd0, redirect_EX}, 32'd0);
      step();
      idle();
      chk("ok_br_pcIF", pc_IF, 32'h204);

      // JAL held under bubbleF, applied after release.
      jal_ID = 1'b1; jal_target_ID = 32'h300; bubbleF = 1'b1; bubbleD = 1'b1;
      step();
      chk("jal_hold_pcIF", pc_IF, 32'h204);
      bubbleF = 1'b0; bubbleD = 1'b0;
      step();
      idle();
      chk("jal_pcIF", pc_IF, 32'h300);

      // Wrap at top of address space.
      jal_ID = 1'b1; jal_target_ID = 32'hFFFF_FFFC;
      step();
      idle();
      chk("wrap_pre", pc_IF, 32'hFFFF_FFFC);
      chk("wrap_addr", {2'b00, addr}, 32'h3FFF_FFFF);
      step();
      chk("wrap_pcIF", pc_IF, 32'h0);
      chk("wrap_pcID", pc_ID, 32'hFFFF_FFFC);

      // Reset wins over a simultaneous JALR.
      step();
      rst = 1'b1; jalr_EX = 1'b1; jalr_target_EX = 32'h0000_0500;
      step();
      idle();
      chk("rst_jalr_pcIF", pc_IF, 32'h0);
      chk("rst_jalr_pcID", pc_ID, 32'h0);

`ifdef BTB_EN
      // Allocate: branch at 0x20 taken to 0x80 (counter=2).
      br_EX = 1'b1; br_taken_EX = 1'b1; pred_taken_EX = 1'b0; pc_EX = 32'h20; br_target_EX = 32'h80;
      step();
      idle();
      chk("btb_alloc_pcIF", pc_IF, 32'h80);
      jal_ID = 1'b1; jal_target_ID = 32'h20;
      step();
      idle();
      chk("btb_fetch20", pc_IF, 32'h20);
      step();
      chk("btb_hit_pcIF", pc_IF, 32'h80);
      chk("btb_hit_pcID", pc_ID, 32'h20);
      chk("btb_hit_pred", {31'd0, pred_taken_ID}, 32'd1);
      // Two not-taken resolutions: counter 2->1->0.
      br_EX = 1'b1; br_taken_EX = 1'b0; pred_taken_EX = 1'b1; pc_EX = 32'h20; br_target_EX = 32'h80;
      step();
      idle();
      chk("btb_nt1_pcIF", pc_IF, 32'h24);
      br_EX = 1'b1; br_taken_EX = 1'b0; pred_taken_EX = 1'b0; pc_EX = 32'h20; br_target_EX = 32'h80;
      step();
      idle();
      chk("btb_nt2_pcIF", pc_IF, 32'h28);
      jal_ID = 1'b1; jal_target_ID = 32'h20;
      step();
      idle();
      step();
      chk("btb_cold_pcIF", pc_IF, 32'h24);
      chk("btb_cold_pred", {31'd0, pred_taken_ID}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
